mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits between the multicycle CPU datapath and the word-wide data RAM.
- The RAM has asynchronous read, synchronous write, word granularity and ignores addr[1:0].
- This block turns CPU load/store requests (LW/LH/LHU/LB/LBU/SW/SH/SB) into RAM word accesses. It handles byte/halfword extraction with sign/zero extension, read-modify-write for sub-word stores, and alignment checking.

Parameters:
- ADDR_W, 32, width of CPU and RAM address buses
- DATA_W, 32, data word width; fixed at 32, other values unsupported

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req  input  1  CPU request strobe; sampled only in IDLE
- op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- addr  input  32  byte address from CPU
- wdata  input  32  store data; SH uses [15:0], SB uses [7:0]
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  misalignment flag, valid only while done=1
- rdata  output  32  load result register
- ram_we  output  1  RAM write enable
- ram_addr  output  32  RAM address, low two bits forced to 0
- ram_wdata  output  32  RAM write word
- ram_rdata  input  32  RAM read word (combinational from ram_addr)

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, err=0, rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Byte order is little-endian: byte k occupies bits [8k+7:8k] at addr[1:0]=k. Halfword at addr[1]=h occupies bits [16h+15:16h].
- Acceptance: in IDLE with req=1, latch op, addr and wdata, then check alignment.
  - Misaligned cases: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1.
  - Misaligned request goes to RESP with err pending and no RAM access.
- FSM states and transitions:
  - IDLE -> LOAD (any load), WRITE (SW), READ (SH/SB), RESP (misaligned).
  - LOAD: ram_addr = latched addr. At the clock edge, capture ram_rdata, extract and extend into rdata, then go to RESP.
  - READ: ram_addr = latched addr. At the clock edge, capture ram_rdata into the merge register, then go to WRITE.
  - WRITE: ram_we=1 for exactly this one cycle, ram_addr = latched addr.
    - SW: ram_wdata = latched wdata.
    - SH/SB: ram_wdata = merge word with only the selected lane replaced.
    - WRITE then goes to RESP.
  - RESP: done=1, err=1 only if misaligned, then return to IDLE.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- rdata update rules:
  - rdata changes only when a load completes.
  - Stores and misaligned requests leave rdata unchanged.
  - rdata holds its value until the next successful load.
- Latency, measured from the accepting edge to the cycle in which done is high:
  - misaligned: 1 cycle
  - loads and SW: 2 cycles
  - SH/SB: 3 cycles
- Earliest next acceptance is the edge after RESP, i.e. the cycle after done.
- req while busy=1 is ignored and not queued; input changes after acceptance have no effect.
- ram_addr and ram_wdata are 0 in IDLE and RESP.
- ram_we is gated by rst, so no RAM write occurs in any cycle where rst=1, including reset asserted during WRITE.
- Reset mid-operation: next edge goes to IDLE, the operation is abandoned with no done pulse, and rdata is reset to 0.
- rst and req in the same cycle: reset wins and the request is dropped.

Test Plan:
- Preload RAM[0x10010000]=0x8899AABB.
  - LB 0x10010001 -> rdata=0xFFFFFFAA, done 2 cycles after accept, err=0.
  - LBU 0x10010003 -> rdata=0x00000088.
  - LH 0x10010002 -> 0xFFFF8899.
  - LHU 0x10010000 -> 0x0000AABB.
- SB 0x10010002, wdata=0x12345677:
  - ram_we high exactly one cycle with ram_wdata=0x8877AABB.
  - done 3 cycles after accept.
  - Following LW 0x10010000 -> 0x8877AABB.
- SH 0x10010001 (misaligned):
  - done and err high 1 cycle after accept, ram_we never asserted.
  - RAM unchanged, rdata unchanged.
- SW 0x10010004, wdata=0xDEADBEEF:
  - ram_we one cycle, ram_addr=0x10010004.
  - req pulses during busy are ignored, with no second write.
  - LW -> 0xDEADBEEF.
- SH 0x10010000 with rst asserted during READ:
  - no ram_we, state IDLE, done=0, rdata=0.
  - Subsequent LW returns the original word.
- Back-to-back: LW issued on the cycle after done is accepted. busy is low only in IDLE; measure throughput as one load per 3 cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end between the multicycle CPU datapath and a word-wide data RAM.
// Splits sub-word accesses into word reads, lane extraction/extension and read-modify-write.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              misaligned;
    logic              is_load;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] store_word;
    logic              ram_active;

    // Alignment is judged on the incoming request so the bad access never reaches the RAM.
    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign is_load = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                     (op == OP_LB) || (op == OP_LBU);

    always_comb begin
        load_byte  = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
        load_half  = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_value = ram_rdata;
        case (op_q)
            OP_LH:   load_value = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_value = {16'h0000, load_half};
            OP_LB:   load_value = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_value = {24'h000000, load_byte};
            default: load_value = ram_rdata;
        endcase
    end

    // Sub-word stores overwrite only their lane of the word captured during READ.
    always_comb begin
        store_word = merge_q;
        case (op_q)
            OP_SW: store_word = wdata_q;
            OP_SH: begin
                if (addr_q[1])
                    store_word[31:16] = wdata_q[15:0];
                else
                    store_word[15:0] = wdata_q[15:0];
            end
            OP_SB:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: store_word = merge_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        err_q   <= misaligned;
                        if (misaligned)
                            state <= ST_RESP;
                        else if (is_load)
                            state <= ST_LOAD;
                        else if (op == OP_SW)
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_LOAD: begin
                    rdata_q <= load_value;
                    state   <= ST_RESP;
                end
                ST_READ: begin
                    merge_q <= ram_rdata;
                    state   <= ST_WRITE;
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ram_active = (state == ST_LOAD) || (state == ST_READ) || (state == ST_WRITE);

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_RESP);
    assign err       = done && err_q;
    assign rdata     = rdata_q;
    // Gating with rst keeps a reset that lands in WRITE from corrupting the RAM.
    assign ram_we    = (state == ST_WRITE) && !rst;
    assign ram_addr  = ram_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign ram_wdata = (state == ST_WRITE) ? store_word : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single transactions plus
// hand-written reset, collision and back-to-back sequences against a small RAM model.
module tb_mem_access_unit;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;
    localparam int NV = 21;

    logic        clk;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:15];
    logic        mem_init;

    int tests;
    int failures;

    int          got_lat;
    int          got_we;
    logic [31:0] got_waddr;
    logic [31:0] got_wword;
    logic        got_err;
    logic [31:0] got_rdata;
    logic [31:0] got_resp_bus;
    logic        got_busy_start;
    logic        got_busy_after;
    time         done_time;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          pulse;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs [0:NV-1];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM covering 0x10010000..0x1001003F; asynchronous read, synchronous write.
    assign ram_rdata = mem[ram_addr[5:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h8899AABB;
        end else if (ram_we) begin
            mem[ram_addr[5:2]] <= ram_wdata;
        end
    end

    task automatic check_output(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (#%0d): got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] w, input bit pulse);
        @(negedge clk);
        got_busy_start = busy;
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        @(posedge clk);
        #1;
        req   = 1'b0;
        op    = ~o;
        addr  = ~a;
        wdata = ~w;
        got_lat = -1;
        got_we = 0;
        got_waddr = 32'h0;
        got_wword = 32'h0;
        got_err = 1'b0;
        got_rdata = 32'hX;
        got_resp_bus = 32'hX;
        got_busy_after = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ram_we) begin
                got_we++;
                got_waddr = ram_addr;
                got_wword = ram_wdata;
            end
            if (done) begin
                got_lat = c;
                got_err = err;
                got_rdata = rdata;
                got_resp_bus = ram_addr | ram_wdata;
                done_time = $time;
                break;
            end
            if (pulse) req = 1'b1;
        end
        // In pulse mode req stays high across the RESP edge, which must not be accepted.
        if (pulse) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            @(negedge clk);
            got_busy_after = busy;
            if (ram_we) got_we++;
        end
        req = 1'b0;
    endtask

    initial begin
        tests = 0;
        failures = 0;
        rst = 1'b1;
        mem_init = 1'b1;
        req = 1'b0;
        op = 3'b000;
        addr = 32'h0;
        wdata = 32'h0;

        vecs[0]  = '{OP_LB,  32'h10010001, 32'h0,        1'b0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[1]  = '{OP_LBU, 32'h10010003, 32'h0,        1'b0, 32'h00000088, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[2]  = '{OP_LH,  32'h10010002, 32'h0,        1'b0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[3]  = '{OP_LHU, 32'h10010000, 32'h0,        1'b0, 32'h0000AABB, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[4]  = '{OP_SB,  32'h10010002, 32'h12345677, 1'b0, 32'h0000AABB, 1'b0, 3, 1, 32'h10010000, 32'h8877AABB};
        vecs[5]  = '{OP_LW,  32'h10010000, 32'h0,        1'b0, 32'h8877AABB, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[6]  = '{OP_SH,  32'h10010001, 32'h0000CAFE, 1'b0, 32'h8877AABB, 1'b1, 1, 0, 32'h0,        32'h0};
        vecs[7]  = '{OP_LW,  32'h10010000, 32'h0,        1'b0, 32'h8877AABB, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[8]  = '{OP_SW,  32'h10010004, 32'hDEADBEEF, 1'b1, 32'h8877AABB, 1'b0, 2, 1, 32'h10010004, 32'hDEADBEEF};
        vecs[9]  = '{OP_LW,  32'h10010004, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[10] = '{OP_LW,  32'h10010006, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1, 0, 32'h0,        32'h0};
        vecs[11] = '{OP_LB,  32'h10010007, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[12] = '{OP_SH,  32'h10010006, 32'h1234F00D, 1'b0, 32'hFFFFFFDE, 1'b0, 3, 1, 32'h10010004, 32'hF00DBEEF};
        vecs[13] = '{OP_LH,  32'h10010006, 32'h0,        1'b0, 32'hFFFFF00D, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[14] = '{OP_LHU, 32'h10010004, 32'h0,        1'b0, 32'h0000BEEF, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[15] = '{OP_SB,  32'h10010008, 32'h00000055, 1'b0, 32'h0000BEEF, 1'b0, 3, 1, 32'h10010008, 32'h00000055};
        vecs[16] = '{OP_LB,  32'h10010008, 32'h0,        1'b0, 32'h00000055, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[17] = '{OP_LBU, 32'h10010005, 32'h0,        1'b0, 32'h000000BE, 1'b0, 2, 0, 32'h0,        32'h0};
        vecs[18] = '{OP_LHU, 32'h10010003, 32'h0,        1'b0, 32'h000000BE, 1'b1, 1, 0, 32'h0,        32'h0};
        vecs[19] = '{OP_SW,  32'h10010002, 32'h01020304, 1'b0, 32'h000000BE, 1'b1, 1, 0, 32'h0,        32'h0};
        vecs[20] = '{OP_LH,  32'h10010000, 32'h0,        1'b0, 32'hFFFFAABB, 1'b0, 2, 0, 32'h0,        32'h0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;

        @(negedge clk);
        check_output("reset_busy",  0, {31'h0, busy},   32'h0);
        check_output("reset_done",  0, {31'h0, done},   32'h0);
        check_output("reset_err",   0, {31'h0, err},    32'h0);
        check_output("reset_rdata", 0, rdata,           32'h0);
        check_output("reset_we",    0, {31'h0, ram_we}, 32'h0);
        check_output("reset_addr",  0, ram_addr,        32'h0);
        check_output("reset_wdata", 0, ram_wdata,       32'h0);

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pulse);
            check_output("latency",  i, got_lat, vecs[i].exp_lat);
            check_output("err",      i, {31'h0, got_err}, {31'h0, vecs[i].exp_err});
            check_output("rdata",    i, got_rdata, vecs[i].exp_rdata);
            check_output("we_count", i, got_we, vecs[i].exp_we);
            check_output("resp_bus_zero", i, got_resp_bus, 32'h0);
            if (vecs[i].exp_we > 0) begin
                check_output("we_addr", i, got_waddr, vecs[i].exp_waddr);
                check_output("we_word", i, got_wword, vecs[i].exp_wword);
            end
            if (vecs[i].pulse)
                check_output("req_in_resp_ignored", i, {31'h0, got_busy_after}, 32'h0);
        end
        check_output("ram_word0", 100, mem[0], 32'h8877AABB);

        // Reset during READ of an SH: abandoned, no write, rdata cleared.
        @(negedge clk);
        req = 1'b1; op = OP_SH; addr = 32'h10010000; wdata = 32'h00001111;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check_output("rst_read_state_busy", 200, {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_read_busy",  200, {31'h0, busy},   32'h0);
        check_output("rst_read_done",  200, {31'h0, done},   32'h0);
        check_output("rst_read_rdata", 200, rdata,           32'h0);
        got_we = 0;
        got_lat = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ram_we) got_we++;
            if (done) got_lat++;
        end
        check_output("rst_read_no_we",   200, got_we,  32'h0);
        check_output("rst_read_no_done", 200, got_lat, 32'h0);
        apply_stimulus(OP_LW, 32'h10010000, 32'h0, 1'b0);
        check_output("rst_read_lw", 200, got_rdata, 32'h8877AABB);

        // Reset asserted while in WRITE must suppress ram_we in that very cycle.
        @(negedge clk);
        req = 1'b1; op = OP_SW; addr = 32'h10010008; wdata = 32'hAAAA5555;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check_output("rst_write_we_before", 201, {31'h0, ram_we}, 32'h1);
        rst = 1'b1;
        #1;
        check_output("rst_write_we_gated", 201, {31'h0, ram_we}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_write_busy", 201, {31'h0, busy}, 32'h0);
        apply_stimulus(OP_LW, 32'h10010008, 32'h0, 1'b0);
        check_output("rst_write_lw", 201, got_rdata, 32'h00000055);

        // Reset and request in the same cycle: request dropped.
        @(negedge clk);
        rst = 1'b1; req = 1'b1; op = OP_LW; addr = 32'h10010004;
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0;
        got_lat = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (busy || done) got_lat++;
        end
        check_output("rst_req_dropped", 202, got_lat, 32'h0);
        check_output("rst_req_rdata",   202, rdata,   32'h0);

        // Back-to-back loads: one accepted per 3 cycles, idle gap visible.
        begin
            time t1;
            apply_stimulus(OP_LW, 32'h10010004, 32'h0, 1'b0);
            t1 = done_time;
            check_output("b2b_first", 203, got_rdata, 32'hF00DBEEF);
            apply_stimulus(OP_LBU, 32'h10010001, 32'h0, 1'b0);
            check_output("b2b_idle_gap", 203, {31'h0, got_busy_start}, 32'h0);
            check_output("b2b_second",   203, got_rdata, 32'h000000AA);
            check_output("b2b_period",   203, 32'(done_time - t1), 32'd30);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
